// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle controller that latches an instruction,
// decodes it and steps the datapath through MOV imm / MOV reg / ADD / CMP /
// AND / MVN. Build option: DATAPATH_SEQ_ILLEGAL_EN enables a sticky
// illegal-opcode flag; when undefined the flag is tied low.
module datapath_sequencer #(
   parameter int unsigned IW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          s,
   input  logic [IW-1:0] in,
   output logic          w,
   output logic [2:0]    readnum,
   output logic [2:0]    writenum,
   output logic          write,
   output logic          loada,
   output logic          loadb,
   output logic          asel,
   output logic          bsel,
   output logic [1:0]    shift,
   output logic [1:0]    ALUop,
   output logic          loadc,
   output logic          loads,
   output logic          vsel,
   output logic [IW-1:0] datapath_in,
   output logic          illegal
);

   localparam int unsigned IMM_W = 8;

   localparam logic [2:0] S_WAIT   = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_GET_A  = 3'd2;
   localparam logic [2:0] S_GET_B  = 3'd3;
   localparam logic [2:0] S_EXEC   = 3'd4;
   localparam logic [2:0] S_WR_REG = 3'd5;
   localparam logic [2:0] S_WR_IMM = 3'd6;

   logic [2:0]    state_q, state_d;
   logic [IW-1:0] ir_q, ir_d;

   logic [2:0] opcode, rn, rd, rm;
   logic [1:0] op, sh;

   logic write_c, loada_c, loadb_c, loadc_c, loads_c;

   assign opcode = ir_q[15:13];
   assign op     = ir_q[12:11];
   assign rn     = ir_q[10:8];
   assign rd     = ir_q[7:5];
   assign sh     = ir_q[4:3];
   assign rm     = ir_q[2:0];

   assign datapath_in = {{(IW-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

`ifdef DATAPATH_SEQ_ILLEGAL_EN
   logic illegal_q, illegal_d;
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   // State, instruction and status registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_WAIT;
         ir_q      <= '0;
`ifdef DATAPATH_SEQ_ILLEGAL_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
`ifdef DATAPATH_SEQ_ILLEGAL_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // Next-state, instruction capture and sticky illegal flag
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
`ifdef DATAPATH_SEQ_ILLEGAL_EN
      illegal_d = illegal_q;
`endif
      case (state_q)
         S_WAIT: begin
            if (s) begin
               state_d = S_DECODE;
`ifdef DATAPATH_SEQ_ILLEGAL_EN
               illegal_d = 1'b0;
`endif
            end else if (load) begin
               ir_d = in;
            end
         end
         S_DECODE: begin
            case ({opcode, op})
               5'b110_10: state_d = S_WR_IMM;
               5'b110_00,
               5'b101_11: state_d = S_GET_B;
               5'b101_00,
               5'b101_01,
               5'b101_10: state_d = S_GET_A;
               default: begin
                  state_d = S_WAIT;
`ifdef DATAPATH_SEQ_ILLEGAL_EN
                  illegal_d = 1'b1;
`endif
               end
            endcase
         end
         S_GET_A:  state_d = S_GET_B;
         S_GET_B:  state_d = S_EXEC;
         // CMP only updates status, so it skips the write-back state
         S_EXEC:   state_d = (opcode == 3'b101 && op == 2'b01) ? S_WAIT : S_WR_REG;
         S_WR_REG: state_d = S_WAIT;
         S_WR_IMM: state_d = S_WAIT;
         default:  state_d = S_WAIT;
      endcase
   end

   // Moore output decode from the current state and IR fields
   always_comb begin
      w        = 1'b0;
      readnum  = 3'd0;
      writenum = 3'd0;
      write_c  = 1'b0;
      loada_c  = 1'b0;
      loadb_c  = 1'b0;
      loadc_c  = 1'b0;
      loads_c  = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      vsel     = 1'b0;
      shift    = 2'b00;
      ALUop    = 2'b00;
      case (state_q)
         S_WAIT:  w = 1'b1;
         S_GET_A: begin
            readnum = rn;
            loada_c = 1'b1;
         end
         S_GET_B: begin
            readnum = rm;
            loadb_c = 1'b1;
         end
         S_EXEC: begin
            shift = sh;
            if (opcode == 3'b110) begin
               asel  = 1'b1;
               ALUop = 2'b00;
            end else begin
               ALUop = op;
            end
            if (opcode == 3'b101 && op == 2'b01) loads_c = 1'b1;
            else                                 loadc_c = 1'b1;
         end
         S_WR_REG: begin
            writenum = rd;
            write_c  = 1'b1;
         end
         S_WR_IMM: begin
            vsel     = 1'b1;
            writenum = rn;
            write_c  = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset suppresses every commit so an interrupted op leaves no trace
   assign write = write_c & ~reset;
   assign loada = loada_c & ~reset;
   assign loadb = loadb_c & ~reset;
   assign loadc = loadc_c & ~reset;
   assign loads = loads_c & ~reset;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a small register-file/ALU model
// driven by the controller outputs to check architectural results.
module tb_datapath_sequencer;

   logic        clk = 1'b0;
   logic        reset, load, s;
   logic [15:0] in;
   logic        w, write, loada, loadb, asel, bsel, loadc, loads, vsel, illegal;
   logic [2:0]  readnum, writenum;
   logic [1:0]  shift, ALUop;
   logic [15:0] datapath_in;

   int n_checks = 0;
   int n_fail   = 0;

   datapath_sequencer dut (
      .clk(clk), .reset(reset), .load(load), .s(s), .in(in),
      .w(w), .readnum(readnum), .writenum(writenum), .write(write),
      .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
      .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
      .vsel(vsel), .datapath_in(datapath_in), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Datapath model: register file, A/B/C, shifter, ALU, Z flag
   logic [15:0] rf [8];
   logic [15:0] ra = '0, rb = '0, rc = '0;
   logic        z_out = 1'b0;
   logic [15:0] b_sh, ain, bin, alu;

   initial for (int i = 0; i < 8; i++) rf[i] = '0;

   always_comb begin
      case (shift)
         2'b01:   b_sh = {rb[14:0], 1'b0};
         2'b10:   b_sh = {1'b0, rb[15:1]};
         2'b11:   b_sh = {rb[15], rb[15:1]};
         default: b_sh = rb;
      endcase
      ain = asel ? 16'h0 : ra;
      bin = bsel ? datapath_in : b_sh;
      case (ALUop)
         2'b00:   alu = ain + bin;
         2'b01:   alu = ain - bin;
         2'b10:   alu = ain & bin;
         default: alu = ~bin;
      endcase
   end

   always @(posedge clk) begin
      if (loada) ra <= rf[readnum];
      if (loadb) rb <= rf[readnum];
      if (loadc) rc <= alu;
      if (loads) z_out <= (alu == 16'h0);
      if (write) rf[writenum] <= vsel ? datapath_in : rc;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load an instruction, start it, and measure the busy window
   task automatic run_op(input logic [15:0] instr, output int cyc, output bit wr, output bit ls);
      in = instr; load = 1'b1; step();
      load = 1'b0; s = 1'b1; step();
      s = 1'b0;
      cyc = 0; wr = 1'b0; ls = 1'b0;
      while (w !== 1'b1 && cyc < 20) begin
         cyc++;
         wr |= write;
         ls |= loads;
         step();
      end
   endtask

   int cyc;
   bit wr, ls;
   bit exp_ill;

   initial begin
`ifdef DATAPATH_SEQ_ILLEGAL_EN
      exp_ill = 1'b1;
`else
      exp_ill = 1'b0;
`endif
      reset = 1'b1; load = 1'b0; s = 1'b0; in = '0;
      step(); step();
      reset = 1'b0;

      // Reset state
      chk("rst_w", 32'(w), 32'd1);
      chk("rst_ctl", 32'({write, loada, loadb, loadc, loads, asel, bsel, vsel}), 32'd0);
      chk("rst_dpin", 32'(datapath_in), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_fields", 32'({readnum, writenum, shift, ALUop}), 32'd0);

      // MOV R0,#7 stepped through by hand
      in = 16'hD007; load = 1'b1; step();
      load = 1'b0; s = 1'b1; step();
      s = 1'b0;
      chk("movi_decode_w", 32'(w), 32'd0);
      step();
      chk("movi_wrimm_ctl", 32'({w, write, vsel}), 32'b011);
      chk("movi_writenum", 32'(writenum), 32'd0);
      chk("movi_dpin", 32'(datapath_in), 32'd7);
      step();
      chk("movi_back_w", 32'(w), 32'd1);
      chk("movi_r0", 32'(rf[0]), 32'd7);

      // Sign extension of imm8 (load only, no start)
      in = 16'hD4FF; load = 1'b1; step(); load = 1'b0;
      chk("sext_dpin", 32'(datapath_in), 32'h0000FFFF);
      chk("sext_idle_w", 32'(w), 32'd1);

      // MOV R1,#2 then MOV R2,R0,LSL#1
      run_op(16'hD102, cyc, wr, ls);
      chk("movi2_cycles", 32'(cyc), 32'd2);
      chk("movi2_r1", 32'(rf[1]), 32'd2);
      in = 16'hC048; load = 1'b1; step();
      load = 1'b0; s = 1'b1; step();
      s = 1'b0; step();
      chk("movr_getb", 32'({readnum, loadb, loada}), 32'({3'd0, 1'b1, 1'b0}));
      step();
      chk("movr_exec", 32'({asel, bsel, shift, ALUop, loadc, loads}), 32'({1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0}));
      step();
      chk("movr_wrreg", 32'({write, writenum, vsel}), 32'({1'b1, 3'd2, 1'b0}));
      step();
      chk("movr_back_w", 32'(w), 32'd1);
      chk("movr_r2", 32'(rf[2]), 32'd14);

      // ADD R3,R1,R0,LSL#1
      run_op(16'hA168, cyc, wr, ls);
      chk("add_cycles", 32'(cyc), 32'd5);
      chk("add_r3", 32'(rf[3]), 32'd16);

      // CMP R0,R0 started with load also high: s wins, IR keeps A800
      in = 16'hA800; load = 1'b1; step();
      in = 16'hD0FF; s = 1'b1; step();
      load = 1'b0; s = 1'b0;
      chk("s_over_load_dpin", 32'(datapath_in), 32'd0);
      cyc = 1; wr = write; ls = loads;
      while (w !== 1'b1 && cyc < 20) begin
         step();
         if (w !== 1'b1) begin
            cyc++;
            wr |= write;
            ls |= loads;
         end
      end
      chk("cmp_cycles", 32'(cyc), 32'd4);
      chk("cmp_no_write", 32'(wr), 32'd0);
      chk("cmp_loads", 32'(ls), 32'd1);
      chk("cmp_z", 32'(z_out), 32'd1);

      // Undecoded instruction
      run_op(16'hE000, cyc, wr, ls);
      chk("ill_cycles", 32'(cyc), 32'd1);
      chk("ill_flag", 32'(illegal), 32'(exp_ill));
      chk("ill_no_write", 32'(wr), 32'd0);
      run_op(16'hD102, cyc, wr, ls);
      chk("ill_cleared", 32'(illegal), 32'd0);

      // Reset while ADD is in EXEC
      in = 16'hA168; load = 1'b1; step();
      load = 1'b0; s = 1'b1; step();
      s = 1'b0; step(); step(); step();
      chk("rst_mid_exec_state", 32'({w, ALUop, shift}), 32'({1'b0, 2'b00, 2'b01}));
      reset = 1'b1; #1;
      chk("rst_mid_gate", 32'({write, loada, loadb, loadc, loads}), 32'd0);
      step();
      reset = 1'b0;
      chk("rst_mid_w", 32'(w), 32'd1);
      chk("rst_mid_loads", 32'({write, loada, loadb, loadc, loads}), 32'd0);
      chk("rst_mid_r3", 32'(rf[3]), 32'd16);
      chk("rst_mid_ir", 32'(datapath_in), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
